seg7_scan_driver: RTL and testbench

//  Parametrised multi-digit 7-segment driver, successor to the fixed per-digit decoders.

---
 rtl/seg7_scan_driver.sv | 242 ++++++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multi-digit 7-segment scan driver with sequential binary-to-BCD
//
// Purpose:
//   Captures a binary value on a load strobe and converts it to BCD one bit per clock
//   (shift-add-3). The display register is updated only when the conversion has
//   finished. DIGITS common-anode displays are time-multiplexed, with optional
//   leading-zero blanking and a dash pattern when the value does not fit.
//
// Ports:
//   clk    in   1        system clock, rising edge
//   rst_n  in   1        asynchronous reset, active-low
//   load   in   1        capture value when busy=0 (single-cycle strobe)
//   value  in   DATA_W   unsigned binary value to display
//   busy   out  1        conversion in progress; load ignored while high
//   seg    out  7        segments gfedcba, active-low, registered
//   an     out  DIGITS   digit enables, active-low one-hot, an[0] = least-significant digit

module seg7_scan_driver #(
  parameter int DATA_W   = 8,
  parameter int DIGITS   = 3,
  parameter int CLK_DIV  = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] value,
  output logic              busy,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SCR_W = BCD_W + DATA_W;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PRE_W = $clog2(CLK_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Largest value representable on DIGITS decimal digits.
  localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS) - 64'd1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Conversion datapath
  logic [SCR_W-1:0] r_scratch;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_next;
  logic [BCD_W-1:0] r_disp;
  logic             r_ovf;

  // Scan datapath
  logic [PRE_W-1:0] r_presc;
  logic [IDX_W-1:0] r_idx;
  logic [6:0]       r_seg;
  logic [DIGITS-1:0] r_an;

  // Combinational helpers
  logic              w_accept;
  logic              w_last_shift;
  logic              w_commit;
  logic              w_value_ovf;
  logic [SCR_W-1:0]  w_scratch_adj;
  logic [SCR_W-1:0]  w_scratch_shift;
  logic [3:0]        w_nib;
  logic              w_higher_nz;
  logic [6:0]        w_seg_next;
  logic [DIGITS-1:0] w_an_next;

  function automatic logic [6:0] decode_digit(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last_shift = 1'b0;
    w_commit     = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (load) begin
          w_accept     = 1'b1;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CNT_W'(DATA_W - 1)) begin
          w_last_shift = 1'b1;
          w_state_next = S_COMMIT;
        end
      end
      S_COMMIT: begin
        // busy stays high through this cycle; it drops at the commit edge.
        w_commit     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        busy         = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Shift-add-3 conversion
  // --------------------------------------------------------------------------
  assign w_value_ovf = (64'(value) > MAX_VAL);

  always_comb begin
    w_scratch_adj = r_scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_scratch[DATA_W + 4*i +: 4] >= 4'd5) begin
        w_scratch_adj[DATA_W + 4*i +: 4] = r_scratch[DATA_W + 4*i +: 4] + 4'd3;
      end
    end
    w_scratch_shift = {w_scratch_adj[SCR_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_next <= 1'b0;
      r_disp     <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_scratch  <= {{BCD_W{1'b0}}, value};
        r_cnt      <= '0;
        r_ovf_next <= w_value_ovf;
      end else if (r_state == S_SHIFT) begin
        r_scratch <= w_scratch_shift;
        if (!w_last_shift) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      // The visible register only ever receives a complete conversion result.
      if (w_commit) begin
        r_disp <= r_scratch[SCR_W-1 -: BCD_W];
        r_ovf  <= r_ovf_next;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scan timing
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      if (r_presc == PRE_W'(CLK_DIV - 1)) begin
        r_presc <= '0;
        if (r_idx == IDX_W'(DIGITS - 1)) begin
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Digit select, blanking and segment decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_nib       = 4'd0;
    w_higher_nz = 1'b0;
    w_an_next   = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(r_idx) == i) begin
        w_nib        = r_disp[4*i +: 4];
        w_an_next[i] = 1'b0;
      end
      // A digit is a leading zero when it and every more-significant digit are zero.
      if ((i >= int'(r_idx)) && (r_disp[4*i +: 4] != 4'd0)) begin
        w_higher_nz = 1'b1;
      end
    end

    if (r_ovf) begin
      w_seg_next = SEG_DASH;
    end else if ((BLANK_LZ != 0) && (r_idx != '0) && !w_higher_nz) begin
      w_seg_next = SEG_BLANK;
    end else begin
      w_seg_next = decode_digit(w_nib);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
    end else begin
      r_seg <= w_seg_next;
      r_an  <= w_an_next;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver

module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] val = 8'd0;
  logic       load_a = 1'b0, load_b = 1'b0, load_c = 1'b0;
  logic       busy_a, busy_b, busy_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic [2:0] an_a;
  logic [1:0] an_b;
  logic [2:0] an_c;

  int errors = 0;
  int checks = 0;

  logic [6:0] seg_tab [10];

  always #5 clk = ~clk;

  // a: 3 digits with blanking, b: 2 digits with blanking, c: 3 digits without blanking
  seg7_scan_driver #(.DATA_W(8), .DIGITS(3), .CLK_DIV(4), .BLANK_LZ(1)) u_a (
    .clk(clk), .rst_n(rst_n), .load(load_a), .value(val),
    .busy(busy_a), .seg(seg_a), .an(an_a));

  seg7_scan_driver #(.DATA_W(8), .DIGITS(2), .CLK_DIV(4), .BLANK_LZ(1)) u_b (
    .clk(clk), .rst_n(rst_n), .load(load_b), .value(val),
    .busy(busy_b), .seg(seg_b), .an(an_b));

  seg7_scan_driver #(.DATA_W(8), .DIGITS(3), .CLK_DIV(4), .BLANK_LZ(0)) u_c (
    .clk(clk), .rst_n(rst_n), .load(load_c), .value(val),
    .busy(busy_c), .seg(seg_c), .an(an_c));

  function automatic int ndig(input int d);
    return (d == 1) ? 2 : 3;
  endfunction

  function automatic int pow10(input int n);
    int r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [7:0] get_an(input int d);
    case (d)
      0:       return {5'b0, an_a};
      1:       return {6'b0, an_b};
      default: return {5'b0, an_c};
    endcase
  endfunction

  function automatic logic [6:0] get_seg(input int d);
    case (d)
      0:       return seg_a;
      1:       return seg_b;
      default: return seg_c;
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  // Expected segment pattern of decimal position pos when v is shown.
  function automatic logic [6:0] model_seg(input int v, input int d, input int pos);
    int nd = ndig(d);
    int blank = (d == 2) ? 0 : 1;
    int digit;
    if (v > pow10(nd) - 1) return 7'b0111111;
    digit = (v / pow10(pos)) % 10;
    if (blank != 0 && pos > 0 && v < pow10(pos)) return 7'b1111111;
    return seg_tab[digit];
  endfunction

  task automatic set_load(input int d, input logic b);
    case (d)
      0:       load_a = b;
      1:       load_b = b;
      default: load_c = b;
    endcase
  endtask

  task automatic do_load(input int d, input int v);
    @(negedge clk);
    val = 8'(v);
    set_load(d, 1'b1);
    @(posedge clk);
    #1;
    set_load(d, 1'b0);
  endtask

  task automatic wait_idle(input int d, input string name);
    int n = 0;
    while (get_busy(d) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (get_busy(d)) begin
      errors++;
      $display("FAIL %s: busy still %0b after %0d cycles, required 0", name, get_busy(d), n);
    end
  endtask

  // Walk one full scan and compare every digit against the model.
  task automatic check_disp(input int d, input int v, input string name);
    int nd = ndig(d);
    logic [7:0] mask = 8'((1 << nd) - 1);
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    int bad_hot = 0;
    bit found;
    @(posedge clk);
    for (int pos = 0; pos < nd; pos++) begin
      exp_an  = ~(8'd1 << pos) & mask;
      exp_seg = model_seg(v, d, pos);
      found   = 0;
      for (int k = 0; k < 40 && !found; k++) begin
        @(negedge clk);
        if ($countones(~get_an(d) & mask) != 1) bad_hot++;
        if (get_an(d) == exp_an) found = 1;
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL %s: an never reached %b (last %b)", name, exp_an, get_an(d));
      end else if (get_seg(d) !== exp_seg) begin
        errors++;
        $display("FAIL %s: value %0d digit %0d seg=%b, required %b", name, v, pos, get_seg(d), exp_seg);
      end
    end
    checks++;
    if (bad_hot != 0) begin
      errors++;
      $display("FAIL %s_onehot: %0d samples with an not one-hot, required 0", name, bad_hot);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (seg_a !== 7'b1111111 || an_a !== 3'b111 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: seg=%b an=%b busy=%b, required 1111111 111 0", seg_a, an_a, busy_a);
    end
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (seg_a !== 7'b1111111 || an_a !== 3'b111 || seg_c !== 7'b1111111 || an_b !== 2'b11) begin
      errors++;
      $display("FAIL reset_async: seg=%b an=%b, required 1111111 111", seg_a, an_a);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (an_a !== 3'b111) begin
      errors++;
      $display("FAIL reset_release: an=%b, required 111", an_a);
    end
    @(posedge clk);
    #1;
    checks++;
    if (an_a !== 3'b110 || seg_a !== 7'b1000000) begin
      errors++;
      $display("FAIL scan_first: an=%b seg=%b, required 110 1000000", an_a, seg_a);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (an_a !== 3'b101 || seg_a !== 7'b1111111) begin
      errors++;
      $display("FAIL scan_second: an=%b seg=%b, required 101 1111111", an_a, seg_a);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (an_a !== 3'b011) begin
      errors++;
      $display("FAIL scan_third: an=%b, required 011", an_a);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (an_a !== 3'b110) begin
      errors++;
      $display("FAIL scan_wrap: an=%b, required 110", an_a);
    end
  endtask

  task automatic test_busy_zero;
    int cnt = 0;
    do_load(0, 0);
    while (busy_a && cnt < 50) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (cnt != 9) begin
      errors++;
      $display("FAIL busy_len: busy high %0d cycles, required 9", cnt);
    end
    check_disp(0, 0, "zero");
  endtask

  task automatic test_inner_zero;
    do_load(0, 205);
    wait_idle(0, "idle_205");
    check_disp(0, 205, "val205");
  endtask

  task automatic test_overflow;
    do_load(1, 100);
    wait_idle(1, "idle_100");
    check_disp(1, 100, "ovf100");
    do_load(1, 99);
    wait_idle(1, "idle_99");
    check_disp(1, 99, "fit99");
  endtask

  task automatic test_back_to_back;
    do_load(0, 205);
    repeat (2) @(posedge clk);
    @(negedge clk);
    val = 8'd17;
    load_a = 1'b1;
    @(posedge clk);
    #1;
    load_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL busy_during: busy=%b, required 1", busy_a);
    end
    wait_idle(0, "idle_ignore");
    check_disp(0, 205, "ignore17");
    do_load(0, 123);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: busy=%b, required 0", busy_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_disp(0, 0, "abort_zero");
    do_load(0, 42);
    wait_idle(0, "idle_42");
    check_disp(0, 42, "after_abort42");
  endtask

  task automatic test_no_blank;
    do_load(2, 15);
    wait_idle(2, "idle_15");
    check_disp(2, 15, "noblank15");
  endtask

  task automatic test_random;
    int v;
    for (int it = 0; it < 12; it++) begin
      int d = it % 3;
      v = $urandom_range(0, 255);
      if (it == 0) v = 255;
      do_load(d, v);
      wait_idle(d, "idle_rand");
      check_disp(d, v, "rand");
    end
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_busy_zero;
    test_inner_zero;
    test_overflow;
    test_back_to_back;
    test_no_blank;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
